dmem_host_write_arbiter: RTL and testbench
==========================================

// Module: dmem_host_write_arbiter
// PURPOSE
//  Shares the data_memory secondary write port (addr_b/din_b/we_b) between core stores and a host loader stream.
//  Host writes are buffered in a small FIFO and drained into cycles where the core does not write memory.
//  A starvation timer forces a core stall, creating bubbles so buffered host writes are never dropped.
//  Sits between the host/debug loader and data_memory; core_stall feeds the core hazard unit.
// PARAMETERS
//  DEPTH       12             data memory byte-address width; matches data_memory DEPTH
//  FIFO_LOG2   2              log2 of host write FIFO entries (default 4 entries)
//  MAX_WAIT    8              consecutive denied cycles before forcing a stall (1..255)
//  UART_ADDR   32'h1000_0000  core store address that does not occupy the memory write port
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  run          in   1   core running; when 0 the core issues no stores and the FIFO drains freely
//  core_we      in   1   core store this cycle (same signal as data_memory we)
//  core_addr    in   32  core store address (same as data_memory addr)
//  host_valid   in   1   host write request
//  host_ready   out  1   FIFO can accept; transfer when host_valid & host_ready
//  host_addr    in   32  host word address (bits [1:0] ignored)
//  host_wdata   in   32  host write data, full word
//  mem_we_b     out  1   to data_memory we_b
//  mem_addr_b   out  32  to data_memory addr_b
//  mem_din_b    out  32  to data_memory din_b
//  core_stall   out  1   registered stall request to core
//  pending      out  FIFO_LOG2+1  FIFO occupancy
//  idle         out  1   FIFO empty and state IDLE
// BEHAVIOUR
//  Reset (reset==0, async): FIFO flushed, pending=0, state=IDLE, wait counter=0, core_stall=0, host_ready=0, mem_we_b=0.
//   host_ready rises the first clk edge after reset is released. Reset mid-burst discards all buffered writes.
//  Port-busy (comb): busy = run & core_we & (core_addr != UART_ADDR).
//  Grant (comb): grant = head_valid & ~busy. mem_we_b = grant; mem_addr_b/mem_din_b = FIFO head (show-ahead).
//   mem_addr_b[1:0] is forced to 2'b00. Host write reaches memory in the same cycle as grant.
//   Minimum latency from host handshake to memory write is 1 cycle (the entry is visible at the head the next cycle).
//  FIFO: ring buffer of 2**FIFO_LOG2 entries with {addr[DEPTH-1:2], data}. Pointers are FIFO_LOG2+1 bits with wrap bit.
//   host_ready = ~full. Simultaneous push and pop when full is not possible (ready=0).
//   Simultaneous push and pop otherwise keeps pending unchanged. Push into an empty FIFO is not granted in the same cycle.
//  FSM (registered):
//   IDLE  : FIFO empty; counter=0. Go to DRAIN when pending becomes non-zero.
//   DRAIN : on each cycle with head_valid & ~grant, counter++. On grant, counter clears.
//           If counter reaches MAX_WAIT-1 while denied, go to FORCE. If the FIFO empties, go to IDLE.
//   FORCE : core_stall=1 (registered, so it is visible the cycle after entry).
//           Stay until a grant occurs; then counter=0 and go to DRAIN (or IDLE if that pop emptied the FIFO).
//  core_stall = (state==FORCE); deasserts the cycle after the forcing grant.
//  Core contract: a stalled core presents core_we=0, so FORCE yields a grant within 2 cycles.
//  Stores to UART_ADDR never block; a host write may be granted in the same cycle.
//  run==0: busy=0, so the FIFO drains at 1 entry/cycle and FORCE is never entered.
//   If run falls while in FORCE, the next cycle grants and the FSM exits.
//  Host writes are never dropped or reordered; memory sees them in handshake order.
// STRUCTURE
//  mspu_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_DRAIN, ARB_FORCE} arb_state_t; localparam UART_ADDR.
//   data_memory uses the same UART_ADDR constant from mspu_pkg.
//  Sub-module: sync_fifo #(WIDTH, LOG2) with a show-ahead head, push/pop, full/empty and count. Everything else is in the top module.
// TESTING
//  Reset: hold reset=0 with host_valid=1 -> host_ready=0, mem_we_b=0, core_stall=0; ready=1 one cycle after release.
//  run=0: push 4 words (addr 0x10,0x14,0x18,0x1C) -> 4 back-to-back mem_we_b pulses in order, pending returns to 0, idle=1.
//  Fill: push 5 with core_we=1 to 0x100 continuously -> 5th handshake blocked (host_ready=0 at pending=4), no loss.
//  Starvation: core stores every cycle, 1 queued write -> core_stall rises after MAX_WAIT=8 denied cycles.
//   Write is granted once core_we=0, and core_stall falls the next cycle.
//  UART bypass: core_we=1 with core_addr=0x1000_0000 and pending=1 -> mem_we_b=1 the same cycle.
//  Async reset mid-FORCE with pending=3 -> core_stall=0 and pending=0 immediately, with no mem_we_b afterward.

Source files
------------

// File: rtl/mspu_pkg.sv
// Shared definitions for the MSPU memory subsystem: host-write arbiter states and the UART
// store address that never occupies the data memory write port.
package mspu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DRAIN,
    ARB_FORCE
  } arb_state_t;

  localparam logic [31:0] UART_ADDR = 32'h1000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous ring-buffer FIFO with a show-ahead head entry. Pointers carry an extra wrap
// bit so that full and empty can be told apart without a separate flag.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LOG2  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    count
);

  localparam logic [LOG2:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [2**LOG2];
  logic [LOG2:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[LOG2] != rptr_q[LOG2]) &&
                   (wptr_q[LOG2-1:0] == rptr_q[LOG2-1:0]);
  assign count   = wptr_q - rptr_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr_q[LOG2-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/dmem_host_write_arbiter.sv
// Shares the data memory secondary write port between core stores and buffered host writes,
// forcing a core stall when host writes have been starved for too long.
module dmem_host_write_arbiter
  import mspu_pkg::*;
#(
  parameter int unsigned DEPTH     = 12,
  parameter int unsigned FIFO_LOG2 = 2,
  parameter int unsigned MAX_WAIT  = 8,
  parameter logic [31:0] UART_ADDR = mspu_pkg::UART_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 core_we,
  input  logic [31:0]          core_addr,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [31:0]          host_addr,
  input  logic [31:0]          host_wdata,
  output logic                 mem_we_b,
  output logic [31:0]          mem_addr_b,
  output logic [31:0]          mem_din_b,
  output logic                 core_stall,
  output logic [FIFO_LOG2:0]   pending,
  output logic                 idle
);

  localparam int unsigned   AW        = DEPTH - 2;
  localparam int unsigned   EW        = AW + 32;
  localparam logic [7:0]    WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [FIFO_LOG2:0] ONE_ENTRY = 1;

  arb_state_t    state_q, state_d;
  logic [7:0]    wait_q, wait_d;
  logic          ready_q;
  logic          busy, grant, push, last_pop, head_valid;
  logic          full, empty;
  logic [EW-1:0] head;
  logic [AW-1:0] head_addr;
  logic          unused_host_addr;

  assign unused_host_addr = ^{host_addr[31:DEPTH], host_addr[1:0]};

  sync_fifo #(
    .WIDTH (EW),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({host_addr[DEPTH-1:2], host_wdata}),
    .pop   (grant),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  // UART stores are decoded elsewhere and leave the memory write port free.
  assign busy       = run & core_we & (core_addr != UART_ADDR);
  assign head_valid = ~empty;
  assign grant      = head_valid & ~busy;

  // ready_q keeps host_ready low until the first clock edge after reset release.
  assign host_ready = ready_q & ~full;
  assign push       = host_valid & host_ready;
  assign last_pop   = grant & ~push & (pending == ONE_ENTRY);

  assign head_addr  = head[EW-1:32];
  assign mem_we_b   = grant;
  assign mem_addr_b = {{(32 - DEPTH){1'b0}}, head_addr, 2'b00};
  assign mem_din_b  = head[31:0];

  assign core_stall = (state_q == ARB_FORCE);
  assign idle       = empty & (state_q == ARB_IDLE);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ARB_IDLE: begin
        wait_d = '0;
        if (push) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (grant) begin
          wait_d = '0;
          if (last_pop) state_d = ARB_IDLE;
        end else if (head_valid) begin
          if (wait_q == WAIT_LAST) state_d = ARB_FORCE;
          else                     wait_d  = wait_q + 8'd1;
        end
      end
      ARB_FORCE: begin
        if (grant) begin
          wait_d  = '0;
          state_d = last_pop ? ARB_IDLE : ARB_DRAIN;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      wait_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ready_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_host_write_arbiter.sv
// Directed and randomized bench for dmem_host_write_arbiter, checked against a queue-based
// model of host writes and a starvation streak counter.
module tb_dmem_host_write_arbiter;

  localparam int          MAX_WAIT = 8;
  localparam logic [31:0] UART     = 32'h1000_0000;

  logic        clk, reset, run, core_we, host_valid, host_ready;
  logic [31:0] core_addr, host_addr, host_wdata;
  logic        mem_we_b, core_stall, idle;
  logic [31:0] mem_addr_b, mem_din_b;
  logic [2:0]  pending;

  int total = 0;
  int bad   = 0;

  // Model state: writes accepted but not yet in memory, as {address, data}.
  logic [63:0] q[$];
  int          streak   = 0;
  bit          rdy_en   = 0;
  bit          stall_now = 0;

  dmem_host_write_arbiter #(
    .DEPTH     (12),
    .FIFO_LOG2 (2),
    .MAX_WAIT  (MAX_WAIT),
    .UART_ADDR (UART)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .mem_we_b   (mem_we_b),
    .mem_addr_b (mem_addr_b),
    .mem_din_b  (mem_din_b),
    .core_stall (core_stall),
    .pending    (pending),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r_rst, input logic r_run, input logic r_we,
                      input logic [31:0] r_caddr, input logic r_hv,
                      input logic [31:0] r_haddr, input logic [31:0] r_hdata);
    bit busy, gnt, rdy;
    int n;
    @(negedge clk);
    reset      = r_rst;
    run        = r_run;
    core_we    = r_we;
    core_addr  = r_caddr;
    host_valid = r_hv;
    host_addr  = r_haddr;
    host_wdata = r_hdata;
    if (!r_rst) begin
      q.delete();
      streak    = 0;
      rdy_en    = 0;
      stall_now = 0;
    end
    #1;
    n    = q.size();
    busy = r_run && r_we && (r_caddr != UART);
    gnt  = (n > 0) && !busy;
    rdy  = rdy_en && (n < 4);
    check("host_ready", 32'(host_ready), 32'(rdy));
    check("mem_we_b", 32'(mem_we_b), 32'(gnt));
    check("core_stall", 32'(core_stall), 32'(stall_now));
    check("pending", 32'(pending), 32'(n));
    check("idle", 32'(idle), 32'(n == 0));
    if (gnt) begin
      check("mem_addr_b", mem_addr_b, q[0][63:32]);
      check("mem_din_b", mem_din_b, q[0][31:0]);
    end
    if (r_rst) begin
      if (gnt) void'(q.pop_front());
      if (gnt)        streak = 0;
      else if (n > 0) streak = streak + 1;
      stall_now = (streak >= MAX_WAIT);
      if (r_hv && rdy) q.push_back({r_haddr & 32'h0000_0FFC, r_hdata});
      rdy_en = 1;
    end
  endtask

  initial begin
    bit          r_rst, r_run, r_we, r_hv;
    logic [31:0] r_caddr;
    reset = 1'b0; run = 1'b0; core_we = 1'b0; core_addr = '0;
    host_valid = 1'b1; host_addr = 32'h40; host_wdata = 32'h1234_5678;

    // Reset held with a host request pending, then release.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 32'h40, 32'h1234_5678);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Core halted: four writes drain back to back.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);

    // Fill while the core hogs the port; fifth push must wait.
    for (int i = 0; i < 6; i++) step(1, 1, 1, 32'h100, 1, 32'hF200 + 32'(4 * i), 32'hB0 + 32'(i));
    for (int i = 0; i < 6; i++) step(1, 1, 1, 32'h100, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h100, 0, 0, 0);

    // Starvation with a single queued write.
    step(1, 1, 1, 32'h104, 1, 32'h300, 32'hC0FF_EE00);
    for (int i = 0; i < 11; i++) step(1, 1, 1, 32'h104, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h104, 0, 0, 0);

    // UART store does not block the port.
    step(1, 1, 1, 32'h108, 1, 32'h404, 32'hD00D_0001);
    step(1, 1, 1, UART, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);

    // Reset while forcing a stall with three writes queued.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h10C, 1, 32'h500 + 32'(4 * i), 32'hE0 + 32'(i));
    for (int i = 0; i < 10; i++) step(1, 1, 1, 32'h10C, 0, 0, 0);
    step(0, 1, 1, 32'h10C, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r_rst   = ($urandom_range(0, 299) != 0);
      r_run   = ($urandom_range(0, 9) != 0);
      r_we    = ($urandom_range(0, 3) != 0);
      if (stall_now && $urandom_range(0, 1) == 1) r_we = 1'b0;
      r_caddr = ($urandom_range(0, 7) == 0) ? UART : $urandom;
      r_hv    = ($urandom_range(0, 1) == 1);
      step(r_rst, r_run, r_we, r_caddr, r_hv, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
